// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter_if
// Description : Requester-side bus into bram_port_arbiter. One instance
//               carries one requester's request, address, write data, byte
//               strobes, completion pulse and read data.
//                 req    requester -> arbiter  held with addr/wdata/wstrb until ack
//                 addr   requester -> arbiter  word address (ADDR bits)
//                 wdata  requester -> arbiter  write data, byte i = [8i+7:8i]
//                 wstrb  requester -> arbiter  0 = read, F = full write, else partial
//                 ack    arbiter -> requester  one-cycle completion pulse
//                 rdata  arbiter -> requester  read data, valid with ack, held
//               master = requester side, slave = arbiter side.
// Revision    : 1.0  initial release
// ============================================================================
interface bram_port_arbiter_if #(
    parameter int ADDR = 8
);
    logic            req;
    logic [ADDR-1:0] addr;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            ack;
    logic [31:0]     rdata;

    modport master (output req, addr, wdata, wstrb, input  ack, rdata);
    modport slave  (input  req, addr, wdata, wstrb, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Shares one port of a word-wide BRAM between two requesters
//               with round-robin grant and one transaction in flight. The
//               BRAM has no byte enables, so partial writes are sequenced as
//               read-modify-write.
// Ports       : clk       port clock (BRAM port domain)
//               reset_n   asynchronous active-low reset
//               m0, m1    requester buses (bram_port_arbiter_if.slave)
//               mem_addr  BRAM address
//               mem_wr    BRAM write strobe
//               mem_din   BRAM write data
//               mem_dout  BRAM read data, RD_LAT cycles after mem_addr
//               busy      high whenever the FSM is not idle
// Revision    : 1.0  initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int ADDR   = 8,
    parameter int RD_LAT = 1
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    bram_port_arbiter_if.slave    m0,
    bram_port_arbiter_if.slave    m1,
    output logic [ADDR-1:0]       mem_addr,
    output logic                  mem_wr,
    output logic [31:0]           mem_din,
    input  wire logic [31:0]      mem_dout,
    output logic                  busy
);

    // WAIT needs to count RD_LAT-1 cycles: values 0 .. RD_LAT-2
    localparam int c_CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(RD_LAT - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_RDATA  = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_last;      // last granted requester (1 = m1)
    logic                r_gnt;       // requester owning the current transaction
    logic [ADDR-1:0]     r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic [31:0]         r_din;
    logic [31:0]         r_rdata0;
    logic [31:0]         r_rdata1;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_any_req;
    logic                w_sel;       // requester chosen in IDLE
    logic                w_is_read;
    logic                w_is_full;
    logic [31:0]         w_merged;
    logic                w_mem_wr;
    logic                w_ack0;
    logic                w_ack1;

    assign w_any_req = m0.req | m1.req;
    // On a tie the requester not granted last time wins; otherwise whoever asks.
    assign w_sel     = (m0.req & m1.req) ? ~r_last : m1.req;
    assign w_is_read = (r_wstrb == 4'h0);
    assign w_is_full = (r_wstrb == 4'hF);

    // Read-modify-write merge: strobed bytes from the latched write data,
    // the rest from the word just read back.
    for (genvar i = 0; i < 4; i++) begin : g_merge
        assign w_merged[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : mem_dout[8*i +: 8];
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs. Outputs depend only on the
    // registered state and latched strobes, never on the req inputs.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mem_wr    = 1'b0;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_is_full) begin
                    w_mem_wr    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (RD_LAT > 1) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_RDATA;
                end
            end
            S_WAIT: begin
                if (r_cnt == c_WAIT_LAST) begin
                    w_state_nxt = S_RDATA;
                end
            end
            S_RDATA: begin
                w_state_nxt = w_is_read ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                w_mem_wr    = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_ack0      = ~r_gnt;
                w_ack1      = r_gnt;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, wait counter, read data and merge register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_din    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= w_sel;
                        r_last  <= w_sel;
                        r_addr  <= w_sel ? m1.addr  : m0.addr;
                        r_wdata <= w_sel ? m1.wdata : m0.wdata;
                        r_wstrb <= w_sel ? m1.wstrb : m0.wstrb;
                        // Full writes drive this straight out during ACCESS
                        r_din   <= w_sel ? m1.wdata : m0.wdata;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_RDATA: begin
                    if (w_is_read) begin
                        if (r_gnt) begin
                            r_rdata1 <= mem_dout;
                        end else begin
                            r_rdata0 <= mem_dout;
                        end
                    end else begin
                        r_din <= w_merged;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign mem_wr   = w_mem_wr;
    assign busy     = (r_state != S_IDLE);
    assign m0.ack   = w_ack0;
    assign m1.ack   = w_ack1;
    assign m0.rdata = r_rdata0;
    assign m1.rdata = r_rdata1;

endmodule
`default_nettype wire
